// File: rtl/ram_rd_pkg.sv
// Shared types and default sizes for the RAM burst reader.
package ram_rd_pkg;

  localparam int RD_AW         = 10;
  localparam int RD_DW         = 32;
  localparam int RD_LEN_W      = 11;
  localparam int RD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic             last;
    logic [RD_DW-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Return buffer for the burst reader: a small synchronous FIFO whose element type
// is a parameter, so the top can store its own {last, data} beat at any data width.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ram_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter type T          = rd_beat_t,
  parameter int  DEPTH      = RD_FIFO_DEPTH,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en;
  logic          rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rd_q];

  // Storage array: holds data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= wdata;
    end
  end

  // Pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Read-side burst master for a dual-port RAM (port B).
// Takes an (address, length) command, issues one read per cycle while credit allows,
// buffers the returns and streams them out with a last flag on the final word.
// In-flight reads plus buffered words never exceed FIFO_DEPTH, so backpressure is lossless.
// Build option READER_WRAP_EN: when defined, bursts wrap around the top of the address
// space; when undefined, a burst that would run past the top is rejected with cmd_err.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int AW         = RD_AW,
  parameter int DW         = RD_DW,
  parameter int LEN_W      = RD_LEN_W,
  parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_err,
  output logic             renb,
  output logic [AW-1:0]    addrb,
  input  logic [DW-1:0]    doutb,
  input  logic             dvalb,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ((AW > LEN_W) ? AW : LEN_W) + 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  rd_state_t        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;     // reads still to issue
  logic [LEN_W-1:0] ret_q, ret_d;     // returns still to arrive, tags last
  logic [LEN_W-1:0] pop_q, pop_d;     // words still to hand downstream
  logic [CW-1:0]    out_q, out_d;     // reads issued but not yet returned
  logic             err_q, err_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW:0]      inflight;
  logic             credit_ok;
  logic             cmd_fire;
  logic             issue;
  logic             ret_ok;
  logic             push;
  logic             pop;
  beat_t            push_beat;
  beat_t            pop_beat;

  // A command is legal when non-empty and, without wrap, it stays inside the RAM.
  function automatic logic cmd_is_legal(input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
    logic ok;
    ok = (l != '0);
`ifdef READER_WRAP_EN
    ok = ok && (SW'(l) <= (SW'(1) << AW));
    if (a == '1) ok = ok;
`else
    ok = ok && ((SW'(a) + SW'(l)) <= (SW'(1) << AW));
`endif
    return ok;
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);

  // Credit: a read may go out only if it still has a guaranteed FIFO slot.
  assign inflight  = {1'b0, out_q} + {1'b0, fifo_count};
  assign credit_ok = (inflight < (CW+1)'(FIFO_DEPTH));
  assign issue     = (state_q == ISSUE) && credit_ok;
  assign renb      = issue;
  assign addrb     = addr_q;

  // A return with nothing outstanding is a leftover from before reset and is dropped.
  assign ret_ok    = dvalb && (out_q != '0);
  assign push      = ret_ok && (!fifo_full || pop);
  assign push_beat = {(ret_q == LEN_W'(1)), doutb};

  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? pop_beat.data : '0;
  assign m_last    = m_valid && pop_beat.last;
  assign cmd_err   = err_q;

  ram_rd_fifo #(
    .T     (beat_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_beat),
    .pop   (pop),
    .rdata (pop_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outstanding-read counter: an issue and a return in the same cycle cancel.
  always_comb begin
    out_d = out_q;
    case ({issue, ret_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  // Burst FSM with address and length bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ret_d   = ret_q;
    pop_d   = pop_q;
    err_d   = 1'b0;
    if (ret_ok) ret_d = ret_q - 1'b1;
    if (pop)    pop_d = pop_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_is_legal(cmd_addr, cmd_len)) begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            ret_d   = cmd_len;
            pop_d   = cmd_len;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (pop_q == LEN_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ret_q   <= '0;
      pop_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ret_q   <= ret_d;
      pop_q   <= pop_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader with a behavioural 1-cycle-latency RAM (mem[i] = i*0x11).
// Expected read addresses and beats are queued when a command is accepted; a monitor
// on the falling edge pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_ram_burst_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LEN_W = 11;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_err;
  logic             renb;
  logic [AW-1:0]    addrb;
  logic [DW-1:0]    doutb;
  logic             dvalb;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic             busy;

  logic [DW-1:0]    mem [1 << AW];
  logic             ram_init;

  exp_t exp_q[$];
  int   exp_addr[$];
  int   checks, errors;
  int   issued, popped, beats;
  int   err_seen, exp_err;
  int   first_valid_cyc, last_pop_cyc, acc_cyc;
  int   cyc;
  int   rdy_mode;

  ram_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_err   (cmd_err),
    .renb      (renb),
    .addrb     (addrb),
    .doutb     (doutb),
    .dvalb     (dvalb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data one cycle after renb, garbage on the bus otherwise.
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 32'h11);
  always @(posedge clk) begin
    if (!ram_init) begin
      dvalb <= 1'b0;
      doutb <= '0;
    end else begin
      dvalb <= renb;
      doutb <= renb ? mem[addrb] : DW'($urandom);
    end
  end

  function automatic void check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic bit model_legal(input int a, input int l);
    if (l == 0) return 1'b0;
`ifdef READER_WRAP_EN
    if (a < 0) return 1'b0;
    return l <= (1 << AW);
`else
    return (a + l) <= (1 << AW);
`endif
  endfunction

  // Reference: a legal burst reads addr..addr+len-1 (mod RAM size) in order.
  function automatic void model_cmd(input int a, input int l);
    if (!model_legal(a, l)) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < l; i++) begin
      int   w;
      exp_t e;
      w = (a + i) % (1 << AW);
      exp_addr.push_back(w);
      e.data = DW'(w * 32'h11);
      e.last = (i == l - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Downstream ready patterns.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Monitor: read addresses, credit bound, stream beats, error pulses.
  always @(negedge clk) begin
    if (rst) begin
      check(cmd_ready == !busy, "ready_vs_busy", cmd_ready, !busy);
      if (renb) begin
        issued++;
        if (exp_addr.size() == 0) begin
          check(1'b0, "renb_unexpected", addrb, 0);
        end else begin
          int a;
          a = exp_addr.pop_front();
          check(addrb == AW'(a), "rd_addr", addrb, a);
        end
        check((issued - popped) <= DEPTH, "credit", issued - popped, DEPTH);
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        popped++;
        beats++;
        if (m_last) last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "beat_unexpected", m_data, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(m_data == e.data, "beat_data", m_data, e.data);
          check(m_last == e.last, "beat_last", m_last, e.last);
        end
      end
      if (cmd_err) err_seen++;
    end
  end

  task automatic send_cmd(input int a, input int l, output int waited);
    waited = 0;
    @(posedge clk);
    #1;
    cmd_addr  = AW'(a);
    cmd_len   = LEN_W'(l);
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 3000) begin
        check(1'b0, "cmd_accept_timeout", waited, 3000);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    check(exp_q.size() == 0, "prev_burst_done_at_accept", exp_q.size(), 0);
    model_cmd(a, l);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_addr.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(t < 3000, name, t, 3000);
  endtask

  initial begin
    int w;
    int e0;
    int t;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    rdy_mode = 0; ram_init = 1'b0;
    checks = 0; errors = 0; issued = 0; popped = 0; beats = 0;
    err_seen = 0; exp_err = 0; first_valid_cyc = -1; last_pop_cyc = -1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b1;
    check(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
    check(renb == 1'b0,    "rst_renb",    renb, 0);
    check(busy == 1'b0,    "rst_busy",    busy, 0);
    check(cmd_err == 1'b0, "rst_cmd_err", cmd_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check(cmd_ready == 1'b1, "post_rst_cmd_ready", cmd_ready, 1);

    // 1: four-word burst at full rate, latency and last placement
    rdy_mode = 0;
    first_valid_cyc = -1; last_pop_cyc = -1;
    send_cmd(1, 4, w);
    t = 0;
    while (last_pop_cyc < 0 && t < 100) begin @(posedge clk); t++; end
    @(negedge clk);
    check(busy == 1'b0, "t1_busy_after_last", busy, 0);
    check(first_valid_cyc == acc_cyc + 2, "t1_first_valid_latency", first_valid_cyc - acc_cyc, 2);
    check(last_pop_cyc - first_valid_cyc == 3, "t1_consecutive_beats", last_pop_cyc - first_valid_cyc, 3);
    wait_drain("t1_drain");

    // 2: eight words with toggling ready
    rdy_mode = 1;
    send_cmd(32, 8, w);
    wait_drain("t2_drain");

    // 3: zero-length command
    e0 = err_seen;
    send_cmd(5, 0, w);
    repeat (3) @(negedge clk);
    check(err_seen - e0 == 1, "t3_err_pulse", err_seen - e0, 1);
    check(busy == 1'b0, "t3_busy", busy, 0);

    // 4: burst across the top of the address space
    rdy_mode = 0;
    e0 = err_seen;
    send_cmd(1022, 4, w);
    wait_drain("t4_drain");
    repeat (2) @(negedge clk);
`ifdef READER_WRAP_EN
    check(err_seen - e0 == 0, "t4_err_pulse", err_seen - e0, 0);
`else
    check(err_seen - e0 == 1, "t4_err_pulse", err_seen - e0, 1);
`endif

    // 5: reset after the fifth beat of a 16-word burst
    rdy_mode = 0;
    beats = 0;
    send_cmd(0, 16, w);
    t = 0;
    while (beats < 5 && t < 200) begin @(posedge clk); t++; end
    check(beats == 5, "t5_reach_beat5", beats, 5);
    #2;
    rst = 1'b0;
    #1;
    check(m_valid == 1'b0, "t5_rst_m_valid", m_valid, 0);
    check(m_last == 1'b0,  "t5_rst_m_last",  m_last, 0);
    check(m_data == '0,    "t5_rst_m_data",  m_data, 0);
    check(renb == 1'b0,    "t5_rst_renb",    renb, 0);
    check(busy == 1'b0,    "t5_rst_busy",    busy, 0);
    exp_q.delete();
    exp_addr.delete();
    issued = 0;
    popped = 0;
    rst = 1'b1;
    send_cmd(16, 2, w);
    wait_drain("t5_drain");

    // 6: second command held off while the first is busy
    rdy_mode = 2;
    send_cmd(64, 8, w);
    send_cmd(80, 3, w);
    check(w > 0, "t6_second_held_off", w, 1);
    wait_drain("t6_drain");

    // Random back-to-back bursts
    for (int n = 0; n < 30; n++) begin
      int a;
      int l;
      rdy_mode = int'($urandom_range(0, 3));
      l = int'($urandom_range(1, 24));
      if ($urandom_range(0, 7) == 0) l = 0;
      a = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 5) == 0) a = (1024 - l + int'($urandom_range(0, 1))) % 1024;
      send_cmd(a, l, w);
    end
    wait_drain("rand_drain");
    repeat (3) @(negedge clk);
    check(err_seen == exp_err, "err_count", err_seen, exp_err);
    check(exp_q.size() == 0, "beats_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
